// File: rtl/asym_fifo_pkg.sv
// Shared constants, types and helpers for the asymmetric (narrow-write, wide-read) FIFO controller.
package asym_fifo_pkg;

    localparam int OBUF_DEPTH = 3;

    // Reads issued to the RAM whose data has not yet been captured.
    typedef logic [1:0] inflight_t;

    // Occupancy of the output buffer, 0..OBUF_DEPTH.
    typedef logic [1:0] obuf_cnt_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/asym_fifo_ctrl_if.sv
// Stream and RAM-port bundle for asym_fifo_ctrl; ASYM_FIFO_STATUS_EN adds level_o/almost_full_o.
// The master modport is the controller itself, the slave modport is its environment.
interface asym_fifo_ctrl_if #(
    parameter int WIDTHA     = 4,
    parameter int WIDTHB     = 16,
    parameter int ADDRWIDTHA = 10,
    parameter int ADDRWIDTHB = 8
);

    logic                  s_valid;
    logic                  s_ready;
    logic [WIDTHA-1:0]     s_data;

    logic                  m_valid;
    logic                  m_ready;
    logic [WIDTHB-1:0]     m_data;

    logic                  ram_ena;
    logic                  ram_wea;
    logic [ADDRWIDTHA-1:0] ram_addra;
    logic [WIDTHA-1:0]     ram_dia;
    logic                  ram_enb;
    logic [ADDRWIDTHB-1:0] ram_addrb;
    logic [WIDTHB-1:0]     ram_dob;

`ifdef ASYM_FIFO_STATUS_EN
    logic [ADDRWIDTHA:0]   level_o;
    logic                  almost_full_o;

    modport master (
        input  s_valid, s_data, m_ready, ram_dob,
        output s_ready, m_valid, m_data,
        output ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb,
        output level_o, almost_full_o
    );

    modport slave (
        output s_valid, s_data, m_ready, ram_dob,
        input  s_ready, m_valid, m_data,
        input  ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb,
        input  level_o, almost_full_o
    );
`else
    modport master (
        input  s_valid, s_data, m_ready, ram_dob,
        output s_ready, m_valid, m_data,
        output ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb
    );

    modport slave (
        output s_valid, s_data, m_ready, ram_dob,
        input  s_ready, m_valid, m_data,
        input  ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb
    );
`endif

endinterface

// File: rtl/asym_fifo_obuf.sv
// Small output FIFO holding wide words returned from the RAM; head is presented as m_data.
// Push and pop may coincide whenever the buffer holds at least one word, even when full.
module asym_fifo_obuf
    import asym_fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output obuf_cnt_t        count_o,
    output logic [WIDTH-1:0] head_o
);

    typedef logic [1:0] idx_t;

    logic [WIDTH-1:0] mem_q [OBUF_DEPTH];
    logic [WIDTH-1:0] mem_d [OBUF_DEPTH];
    idx_t             wr_idx_q, wr_idx_d;
    idx_t             rd_idx_q, rd_idx_d;
    obuf_cnt_t        count_q, count_d;
    logic             do_push, do_pop;

    function automatic idx_t next_idx(input idx_t idx);
        return (idx == idx_t'(OBUF_DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != obuf_cnt_t'(OBUF_DEPTH)) || do_pop);

        if (do_push) begin
            mem_d[wr_idx_q] = push_data_i;
            wr_idx_d        = next_idx(wr_idx_q);
        end
        if (do_pop) begin
            rd_idx_d = next_idx(rd_idx_q);
        end
        count_d = count_q + obuf_cnt_t'(do_push) - obuf_cnt_t'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset on purpose, because m_data must read zero straight out of reset.
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking updates, so every flop samples the values from before the edge.
            mem_q    <= mem_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_idx_q];

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Single-clock FIFO controller driving an external narrow-write / wide-read RAM.
// Define ASYM_FIFO_STATUS_EN to export the fill level and an almost-full flag.
module asym_fifo_ctrl
    import asym_fifo_pkg::*;
#(
    parameter int WIDTHA     = 4,
    parameter int WIDTHB     = 16,
    parameter int ADDRWIDTHA = 10,
    parameter int ADDRWIDTHB = 8
) (
    input logic              clk,
    input logic              rst_n,
    asym_fifo_ctrl_if.master bus
);

    localparam int RATIO = WIDTHB / WIDTHA;
    localparam int L     = clog2(RATIO);
    localparam logic [ADDRWIDTHA:0] SIZE_A = {1'b1, {ADDRWIDTHA{1'b0}}};

    logic [ADDRWIDTHA:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTHB:0] rd_issue_ptr_q, rd_issue_ptr_d;
    logic [ADDRWIDTHB:0] rd_commit_ptr_q, rd_commit_ptr_d;
    inflight_t           inflight_q, inflight_d;
    logic                rd_pending_q, rd_pending_d;

    logic [ADDRWIDTHA:0] level;
    logic [ADDRWIDTHB:0] avail;
    logic                s_ready;
    logic                accept;
    logic                issue;
    logic                pop;

    logic                obuf_empty;
    obuf_cnt_t           obuf_count;
    logic [WIDTHB-1:0]   obuf_head;

    // RAM space is released only at commit, so a write never lands on a word still being read.
    always_comb begin
        level   = wr_ptr_q - {rd_commit_ptr_q, {L{1'b0}}};
        avail   = wr_ptr_q[ADDRWIDTHA:L] - rd_issue_ptr_q;
        s_ready = (level != SIZE_A);
        accept  = bus.s_valid & s_ready;
        issue   = (avail != '0) &&
                  (({1'b0, obuf_count} + {1'b0, inflight_q}) < 3'(OBUF_DEPTH));
        pop     = !obuf_empty & bus.m_ready;
    end

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_issue_ptr_d  = rd_issue_ptr_q;
        rd_commit_ptr_d = rd_commit_ptr_q;
        rd_pending_d    = issue;
        inflight_d      = inflight_q + inflight_t'(issue) - inflight_t'(rd_pending_q);

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_issue_ptr_d = rd_issue_ptr_q + 1'b1;
        end
        if (rd_pending_q) begin
            rd_commit_ptr_d = rd_commit_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q        <= '0;
            rd_issue_ptr_q  <= '0;
            rd_commit_ptr_q <= '0;
            inflight_q      <= '0;
            rd_pending_q    <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_issue_ptr_q  <= rd_issue_ptr_d;
            rd_commit_ptr_q <= rd_commit_ptr_d;
            inflight_q      <= inflight_d;
            rd_pending_q    <= rd_pending_d;
        end
    end

    // Read data arrives one cycle after issue and is captured at the end of that cycle.
    asym_fifo_obuf #(
        .WIDTH (WIDTHB)
    ) u_obuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rd_pending_q),
        .push_data_i (bus.ram_dob),
        .pop_i       (pop),
        .empty_o     (obuf_empty),
        .count_o     (obuf_count),
        .head_o      (obuf_head)
    );

    assign bus.s_ready   = s_ready;
    assign bus.ram_ena   = accept;
    assign bus.ram_wea   = accept;
    assign bus.ram_addra = wr_ptr_q[ADDRWIDTHA-1:0];
    assign bus.ram_dia   = bus.s_data;
    assign bus.ram_enb   = issue;
    assign bus.ram_addrb = rd_issue_ptr_q[ADDRWIDTHB-1:0];
    assign bus.m_valid   = !obuf_empty;
    assign bus.m_data    = obuf_head;

`ifdef ASYM_FIFO_STATUS_EN
    localparam logic [ADDRWIDTHA:0] AF_THRESH = SIZE_A - (ADDRWIDTHA + 1)'(RATIO);

    assign bus.level_o       = level;
    assign bus.almost_full_o = (level >= AF_THRESH);
`endif

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// Self-checking bench for asym_fifo_ctrl: behavioural RAM, nibble-packing scoreboard, directed and random traffic.
`timescale 1ns/1ps
module tb_asym_fifo_ctrl;

    localparam int WIDTHA     = 4;
    localparam int WIDTHB     = 16;
    localparam int ADDRWIDTHA = 10;
    localparam int ADDRWIDTHB = 8;
    localparam int RATIO      = WIDTHB / WIDTHA;
    localparam int SIZEA      = 1 << ADDRWIDTHA;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    asym_fifo_ctrl_if #(
        .WIDTHA(WIDTHA), .WIDTHB(WIDTHB), .ADDRWIDTHA(ADDRWIDTHA), .ADDRWIDTHB(ADDRWIDTHB)
    ) bus ();

    asym_fifo_ctrl #(
        .WIDTHA(WIDTHA), .WIDTHB(WIDTHB), .ADDRWIDTHA(ADDRWIDTHA), .ADDRWIDTHB(ADDRWIDTHB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural asymmetric RAM: narrow write port, registered wide read port.
    logic [WIDTHA-1:0] ram [SIZEA];

    always @(posedge clk) begin
        if (bus.ram_ena && bus.ram_wea) begin
            ram[bus.ram_addra] <= bus.ram_dia;
        end
        if (bus.ram_enb) begin
            for (int k = 0; k < RATIO; k++) begin
                bus.ram_dob[k*WIDTHA +: WIDTHA] <= ram[int'(bus.ram_addrb) * RATIO + k];
            end
        end
    end

    logic [WIDTHA-1:0] nib_q[$];
    logic [WIDTHB-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_accept = 0;
    int n_pop    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: every RATIO accepted nibbles form one wide word, oldest nibble in the LSBs.
    task automatic model_write(input logic [WIDTHA-1:0] d);
        logic [WIDTHB-1:0] w;
        nib_q.push_back(d);
        if (nib_q.size() == RATIO) begin
            w = '0;
            for (int k = RATIO - 1; k >= 0; k--) begin
                w = (w << WIDTHA) | WIDTHB'(nib_q[k]);
            end
            exp_q.push_back(w);
            nib_q.delete();
        end
    endtask

    // One clock cycle: drive after the falling edge, sample handshakes, then wait for the next falling edge.
    task automatic cycle(input logic sv, input logic [WIDTHA-1:0] sd, input logic mr);
        logic [WIDTHB-1:0] e;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        #1;
        if (sv && bus.s_ready) begin
            model_write(sd);
            n_accept++;
        end
        if (bus.m_valid && mr) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(bus.m_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("m_data", 32'(bus.m_data), 32'(e));
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(output int edges);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        edges = 0;
        #1;
        while (!bus.m_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && guard < 2000) begin
            cycle(1'b0, '0, 1'b1);
            guard++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.s_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        int start;
        int start_pop;
        int guard;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_ram_wea", 32'(bus.ram_wea), 32'd0);
        check("rst_ram_enb", 32'(bus.ram_enb), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
`ifdef ASYM_FIFO_STATUS_EN
        check("rst_level", 32'(bus.level_o), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic pack and first-word latency.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0);
        wait_valid(lat);
        check("pack_latency", 32'(lat), 32'd2);
        check("pack_data", 32'(bus.m_data), 32'h4321);
        drain("pack");

        // Partial word stays invisible until completed.
        cycle(1'b1, 4'hA, 1'b1);
        cycle(1'b1, 4'hB, 1'b1);
        cycle(1'b1, 4'hC, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (bus.m_valid) seen++;
        end
        check("partial_hold", 32'(seen), 32'd0);
        cycle(1'b1, 4'hD, 1'b0);
        wait_valid(lat);
        check("partial_data", 32'(bus.m_data), 32'hDCBA);
        drain("partial");

        // Fill with the consumer stalled: RAM plus the three buffered words.
        start = n_accept;
        guard = 0;
        while (bus.s_ready && guard < 1200) begin
            cycle(1'b1, 4'(n_accept), 1'b0);
            guard++;
        end
        check("full_accepts", 32'(n_accept - start), 32'(SIZEA + 3 * RATIO));
        check("full_ready_low", 32'(bus.s_ready), 32'd0);
`ifdef ASYM_FIFO_STATUS_EN
        check("full_level", 32'(bus.level_o), 32'(SIZEA));
        check("full_almost_full", 32'(bus.almost_full_o), 32'd1);
`endif
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 4'hF;
            #1;
            check("full_wea_blocked", 32'(bus.ram_wea), 32'd0);
            @(negedge clk);
        end
        drain("full");

        // Consumer toggling ready every cycle.
        start     = n_accept;
        start_pop = n_pop;
        guard     = 0;
        while ((n_accept - start) < 64 * RATIO && guard < 2000) begin
            cycle(1'b1, 4'(n_accept - start), guard[0]);
            guard++;
        end
        drain("bp");
        check("bp_words", 32'(n_pop - start_pop), 32'd64);

        // Random traffic across pointer wrap, often running full.
        start     = n_accept;
        start_pop = n_pop;
        guard     = 0;
        while ((n_accept - start) < 3000 && guard < 20000) begin
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 7) == 0));
            guard++;
        end
        check("wrap_accepts", 32'(n_accept - start), 32'd3000);
        drain("wrap");
        check("wrap_words", 32'(n_pop - start_pop), 32'd750);

        // Reset while reads are in flight: everything is discarded.
        for (int i = 0; i < 12; i++) cycle(1'b1, 4'(i + 9), 1'b0);
        bus.s_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        check("midrst_s_ready", 32'(bus.s_ready), 32'd1);
        nib_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 5; i <= 8; i++) cycle(1'b1, 4'(i), 1'b0);
        wait_valid(lat);
        check("postrst_latency", 32'(lat), 32'd2);
        check("postrst_data", 32'(bus.m_data), 32'h8765);
        drain("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
